// File: rtl/packet_sender.sv
// ---------------------------------------------------------------------------
// packet_sender
//
// Purpose:
//   Upstream stage of packet_receiver. Accepts a header command (src, dest,
//   size) and a payload byte stream from the host side, then serialises one
//   packet on pdata as: src, dest, size, payload[0..size-1], crc.
//   crc is the XOR of all payload bytes. A byte is emitted only on edges
//   where stop_packet_send is low; otherwise the receiver sees a gap.
//
// Parameters:
//   MAX_PAYLOAD  largest legal size byte (payload + 4 fits a 16-entry FIFO)
//   STAT_W       width of the statistics counters (stats build only)
//
// Ports:
//   clk1              in   single clock, rising edge
//   rst               in   asynchronous, active-low reset
//   cmd_valid         in   header command valid
//   cmd_ready         out  high in IDLE; command taken on valid & ready
//   cmd_src           in   source id byte
//   cmd_dest          in   destination id byte
//   cmd_size          in   payload length in bytes
//   pl_valid          in   payload byte valid
//   pl_ready          out  payload byte taken on pl_valid & pl_ready
//   pl_data           in   payload byte
//   stop_packet_send  in   backpressure from packet_receiver
//   packet_valid_o    out  pdata carries a packet byte this cycle
//   pdata             out  packet byte (holds when packet_valid_o is low)
//   err_size          out  one-cycle pulse: command rejected (bad size)
//   busy              out  packet in progress
//
// Configuration:
//   PKT_SENDER_STATS_EN  when defined, adds saturating counters
//                        pkt_cnt, stall_cnt and err_cnt [STAT_W-1:0].
//                        When undefined those ports do not exist.
// ---------------------------------------------------------------------------
module packet_sender #(
    parameter int MAX_PAYLOAD = 12
`ifdef PKT_SENDER_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_src,
    input  logic [7:0] cmd_dest,
    input  logic [7:0] cmd_size,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       stop_packet_send,
    output logic       packet_valid_o,
    output logic [7:0] pdata,
    output logic       err_size,
    output logic       busy
`ifdef PKT_SENDER_STATS_EN
    ,
    output logic [STAT_W-1:0] pkt_cnt,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] err_cnt
`endif
);

    // State names the last byte emitted; SRC_WAIT holds an accepted
    // command whose src byte was blocked by backpressure.
    typedef enum logic [2:0] {
        IDLE,
        SRC_WAIT,
        SRC,
        DEST,
        SIZE,
        DATA,
        CRC
    } state_t;

    localparam logic [7:0] MAX_SIZE = 8'(MAX_PAYLOAD);

    state_t     state;
    logic [7:0] src_q;
    logic [7:0] dest_q;
    logic [7:0] size_q;
    logic [7:0] remaining;
    logic [7:0] crc;

    logic adv;
    logic size_legal;
    logic pl_fire;
    logic payload_left;

    // Handshake and qualifier terms. Payload is only taken on an edge where
    // the byte can also be emitted, so stop never loses or repeats a byte.
    assign adv          = !stop_packet_send;
    assign size_legal   = (cmd_size != 8'd0) && (cmd_size <= MAX_SIZE);
    assign payload_left = (remaining != 8'd0);
    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign pl_ready     = adv && ((state == SIZE) ||
                                  ((state == DATA) && payload_left));
    assign pl_fire      = pl_valid && pl_ready;

    // Packet serialiser. Every edge either emits the next byte with
    // packet_valid_o high, or drops valid and leaves pdata unchanged.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            src_q          <= 8'd0;
            dest_q         <= 8'd0;
            size_q         <= 8'd0;
            remaining      <= 8'd0;
            crc            <= 8'd0;
            packet_valid_o <= 1'b0;
            pdata          <= 8'd0;
            err_size       <= 1'b0;
        end else begin
            packet_valid_o <= 1'b0;
            err_size       <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (size_legal) begin
                            src_q  <= cmd_src;
                            dest_q <= cmd_dest;
                            size_q <= cmd_size;
                            crc    <= 8'd0;
                            if (adv) begin
                                pdata          <= cmd_src;
                                packet_valid_o <= 1'b1;
                                state          <= SRC;
                            end else begin
                                state <= SRC_WAIT;
                            end
                        end else begin
                            err_size <= 1'b1;
                        end
                    end
                end

                SRC_WAIT: begin
                    if (adv) begin
                        pdata          <= src_q;
                        packet_valid_o <= 1'b1;
                        state          <= SRC;
                    end
                end

                SRC: begin
                    if (adv) begin
                        pdata          <= dest_q;
                        packet_valid_o <= 1'b1;
                        state          <= DEST;
                    end
                end

                DEST: begin
                    if (adv) begin
                        pdata          <= size_q;
                        packet_valid_o <= 1'b1;
                        remaining      <= size_q;
                        state          <= SIZE;
                    end
                end

                // SIZE always has payload left because size 0 is rejected.
                // A missing payload byte just produces a gap, no timeout.
                SIZE, DATA: begin
                    if (payload_left) begin
                        if (pl_fire) begin
                            pdata          <= pl_data;
                            packet_valid_o <= 1'b1;
                            crc            <= crc ^ pl_data;
                            remaining      <= remaining - 8'd1;
                            state          <= DATA;
                        end
                    end else if (adv) begin
                        pdata          <= crc;
                        packet_valid_o <= 1'b1;
                        state          <= CRC;
                    end
                end

                // Guaranteed idle cycle between packets.
                CRC: begin
                    crc   <= 8'd0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PKT_SENDER_STATS_EN
    // Saturating statistics: completed packets, busy cycles without an
    // emitted byte, and rejected commands.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            pkt_cnt   <= '0;
            stall_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if ((state == DATA) && !payload_left && adv && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + STAT_W'(1);
            end
            if (busy && !packet_valid_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
            if ((state == IDLE) && cmd_valid && !size_legal && (err_cnt != '1)) begin
                err_cnt <= err_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule
